writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_core.sv | 65 ++++++
 rtl/writeback_regfile.sv | 50 +++++
 tb/tb_writeback_regfile.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing constants for the writeback register file.
// Index width stays 5 bits to match the MIPS-style register specifiers.
package regfile_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CW    = 32;

  localparam logic [AW-1:0] ZERO_REG = AW'(0);

  // A write only commits when enabled and not aimed at the hardwired zero register.
  function automatic logic is_commit(input logic we, input logic [AW-1:0] addr);
    return we && (addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Flop-based register storage with one write port, two bypassing read ports
// and a hardwired zero register.
module regfile_core
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = regfile_pkg::NREGS,
  parameter int unsigned DW    = regfile_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);

  // Entry 0 is never stored; it always reads as zero.
  logic [DW-1:0] regs [1:NREGS-1];
  logic          commit;

  assign commit = is_commit(we, waddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        if (waddr == AW'(i)) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  // Same-cycle bypass lets decode see the value being written this edge.
  always_comb begin
    rd1 = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (a1 == AW'(i)) begin
        rd1 = regs[i];
      end
    end
    if (commit && (a1 == waddr)) begin
      rd1 = wdata;
    end
  end

  always_comb begin
    rd2 = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (a2 == AW'(i)) begin
        rd2 = regs[i];
      end
    end
    if (commit && (a2 == waddr)) begin
      rd2 = wdata;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the result, commits it to the register file
// and counts committed writes.
module writeback_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = regfile_pkg::NREGS,
  parameter int unsigned DW    = regfile_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RegWriteW,
  input  logic          MemtoRegW,
  input  logic [DW-1:0] ReadDataW,
  input  logic [DW-1:0] ALUOutW,
  input  logic [AW-1:0] WriteRegW,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic [DW-1:0] ResultW,
  output logic [CW-1:0] WbCount
);

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

  // Reset wins over a coincident commit, so that commit is never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      WbCount <= '0;
    end else if (is_commit(RegWriteW, WriteRegW)) begin
      WbCount <= WbCount + CW'(1);
    end
  end

  regfile_core #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .we    (RegWriteW),
    .waddr (WriteRegW),
    .wdata (ResultW),
    .a1    (A1),
    .a2    (A2),
    .rd1   (RD1),
    .rd2   (RD2)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile.
module tb_writeback_regfile;

  logic        clk;
  logic        reset;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ResultW;
  logic [31:0] WbCount;

  int checks;
  int errors;

  writeback_regfile dut (
    .clk       (clk),
    .reset     (reset),
    .RegWriteW (RegWriteW),
    .MemtoRegW (MemtoRegW),
    .ReadDataW (ReadDataW),
    .ALUOutW   (ALUOutW),
    .WriteRegW (WriteRegW),
    .A1        (A1),
    .A2        (A2),
    .RD1       (RD1),
    .RD2       (RD2),
    .ResultW   (ResultW),
    .WbCount   (WbCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    RegWriteW = 1'b0;
    MemtoRegW = 1'b0;
    ReadDataW = 32'h0;
    ALUOutW   = 32'h0;
    WriteRegW = 5'd0;
  endtask

  // Step past one active edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    A1 = 5'd5;
    A2 = 5'd31;
    step();
    step();
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h exp %h", RD2, 32'h0); end
    checks++;
    if (WbCount !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp %h", WbCount, 32'h0); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu_bypass();
    @(negedge clk);
    RegWriteW = 1'b1;
    MemtoRegW = 1'b0;
    ALUOutW   = 32'h1234;
    ReadDataW = 32'hCAFE_0000;
    WriteRegW = 5'd8;
    A1 = 5'd8;
    A2 = 5'd5;
    #1;
    checks++;
    if (RD1 !== 32'h1234) begin errors++; $display("FAIL alu_bypass_rd1 got %h exp %h", RD1, 32'h1234); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("FAIL alu_bypass_rd2 got %h exp %h", RD2, 32'h0); end
    step();
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (RD1 !== 32'h1234) begin errors++; $display("FAIL alu_stored_rd1 got %h exp %h", RD1, 32'h1234); end
    checks++;
    if (WbCount !== 32'd1) begin errors++; $display("FAIL alu_count got %h exp %h", WbCount, 32'd1); end
  endtask

  task automatic test_mem_load();
    @(negedge clk);
    RegWriteW = 1'b1;
    MemtoRegW = 1'b1;
    ReadDataW = 32'hDEAD_BEEF;
    ALUOutW   = 32'h1;
    WriteRegW = 5'd3;
    A1 = 5'd0;
    A2 = 5'd0;
    #1;
    checks++;
    if (ResultW !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mem_resultw got %h exp %h", ResultW, 32'hDEAD_BEEF); end
    MemtoRegW = 1'b1;
    step();
    @(negedge clk);
    idle();
    A1 = 5'd3;
    #1;
    checks++;
    if (ResultW !== 32'h0) begin errors++; $display("FAIL alu_resultw got %h exp %h", ResultW, 32'h0); end
    checks++;
    if (RD1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mem_stored got %h exp %h", RD1, 32'hDEAD_BEEF); end
    checks++;
    if (WbCount !== 32'd2) begin errors++; $display("FAIL mem_count got %h exp %h", WbCount, 32'd2); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    RegWriteW = 1'b1;
    MemtoRegW = 1'b0;
    ALUOutW   = 32'hFFFF;
    WriteRegW = 5'd0;
    A1 = 5'd0;
    A2 = 5'd0;
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("FAIL zero_pre_rd1 got %h exp %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("FAIL zero_pre_rd2 got %h exp %h", RD2, 32'h0); end
    step();
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("FAIL zero_post_rd1 got %h exp %h", RD1, 32'h0); end
    checks++;
    if (WbCount !== 32'd2) begin errors++; $display("FAIL zero_count got %h exp %h", WbCount, 32'd2); end
  endtask

  task automatic test_dual_bypass();
    @(negedge clk);
    RegWriteW = 1'b1;
    MemtoRegW = 1'b0;
    ALUOutW   = 32'hA5A5_5A5A;
    WriteRegW = 5'd12;
    A1 = 5'd12;
    A2 = 5'd12;
    #1;
    checks++;
    if (RD1 !== 32'hA5A5_5A5A) begin errors++; $display("FAIL dual_rd1 got %h exp %h", RD1, 32'hA5A5_5A5A); end
    checks++;
    if (RD2 !== 32'hA5A5_5A5A) begin errors++; $display("FAIL dual_rd2 got %h exp %h", RD2, 32'hA5A5_5A5A); end
    A1 = 5'd3;
    #1;
    checks++;
    if (RD1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL split_rd1 got %h exp %h", RD1, 32'hDEAD_BEEF); end
    checks++;
    if (RD2 !== 32'hA5A5_5A5A) begin errors++; $display("FAIL split_rd2 got %h exp %h", RD2, 32'hA5A5_5A5A); end
    step();
    @(negedge clk);
    idle();
    A1 = 5'd8;
    A2 = 5'd12;
    #1;
    checks++;
    if (RD1 !== 32'h1234) begin errors++; $display("FAIL dual_keep8 got %h exp %h", RD1, 32'h1234); end
    checks++;
    if (RD2 !== 32'hA5A5_5A5A) begin errors++; $display("FAIL dual_stored got %h exp %h", RD2, 32'hA5A5_5A5A); end
    checks++;
    if (WbCount !== 32'd3) begin errors++; $display("FAIL dual_count got %h exp %h", WbCount, 32'd3); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    RegWriteW = 1'b1;
    MemtoRegW = 1'b0;
    ALUOutW   = 32'h11;
    WriteRegW = 5'd5;
    A1 = 5'd5;
    A2 = 5'd0;
    @(negedge clk);
    ALUOutW = 32'h22;
    #1;
    checks++;
    if (RD1 !== 32'h22) begin errors++; $display("FAIL b2b_bypass got %h exp %h", RD1, 32'h22); end
    RegWriteW = 1'b0;
    #1;
    checks++;
    if (RD1 !== 32'h11) begin errors++; $display("FAIL b2b_first got %h exp %h", RD1, 32'h11); end
    RegWriteW = 1'b1;
    step();
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (RD1 !== 32'h22) begin errors++; $display("FAIL b2b_final got %h exp %h", RD1, 32'h22); end
    checks++;
    if (WbCount !== 32'd5) begin errors++; $display("FAIL b2b_count got %h exp %h", WbCount, 32'd5); end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset     = 1'b1;
    RegWriteW = 1'b1;
    MemtoRegW = 1'b0;
    ALUOutW   = 32'h99;
    WriteRegW = 5'd9;
    A1 = 5'd9;
    A2 = 5'd8;
    #1;
    checks++;
    if (RD1 !== 32'h99) begin errors++; $display("FAIL rst_bypass got %h exp %h", RD1, 32'h99); end
    step();
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("FAIL rst_reg9 got %h exp %h", RD1, 32'h0); end
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("FAIL rst_reg8 got %h exp %h", RD2, 32'h0); end
    checks++;
    if (WbCount !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp %h", WbCount, 32'h0); end
    RegWriteW = 1'b1;
    ALUOutW   = 32'h77;
    WriteRegW = 5'd9;
    step();
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (RD1 !== 32'h77) begin errors++; $display("FAIL post_rst_reg9 got %h exp %h", RD1, 32'h77); end
    checks++;
    if (WbCount !== 32'd1) begin errors++; $display("FAIL post_rst_count got %h exp %h", WbCount, 32'd1); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    idle();
    force dut.WbCount = 32'hFFFF_FFFF;
    #1;
    release dut.WbCount;
    #1;
    checks++;
    if (WbCount !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h exp %h", WbCount, 32'hFFFF_FFFF); end
    RegWriteW = 1'b1;
    ALUOutW   = 32'h5;
    WriteRegW = 5'd20;
    step();
    checks++;
    if (WbCount !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp %h", WbCount, 32'h0); end
    step();
    checks++;
    if (WbCount !== 32'd1) begin errors++; $display("FAIL wrap_next got %h exp %h", WbCount, 32'd1); end
    @(negedge clk);
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    A1 = 5'd0;
    A2 = 5'd0;
    idle();
    test_reset();
    test_alu_bypass();
    test_mem_load();
    test_zero_reg();
    test_dual_bypass();
    test_back_to_back();
    test_reset_priority();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
